// File: rtl/matmul_run_sequencer.sv
// matmul_run_sequencer: queues host run commands and pulses accelerator run until each repeat count is spent; optional watchdog via MATMUL_SEQ_WATCHDOG_EN
module matmul_run_sequencer #(
  parameter int CNT_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_iters,
  output logic             run,
  input  logic             done,
  output logic             busy,
  output logic             cmd_done,
  output logic [31:0]      runs_total,
  output logic             error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, WAIT} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CNT_W-1:0] remaining, head;
  logic push, pop, last, finish, timeout;
  assign head = mem[rd_ptr];
  assign cmd_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push = cmd_valid & cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign finish = state == WAIT && done;
  assign last = remaining <= CNT_W'(1);
  assign run = state == RUN;
  assign busy = state != IDLE || count != '0;
`ifdef MATMUL_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  assign timeout = state == WAIT && !done && wd >= WD_W'(TIMEOUT - 1);
  // cycles since the last run pulse; expiry latches error until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
      error <= 1'b0;
    end else begin
      wd <= run ? '0 : (state != IDLE ? wd + WD_W'(1) : wd);
      error <= error | timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  // next state: a run pulse is always followed by one settle cycle before done is trusted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (pop && head != '0) ? RUN : IDLE;
      RUN:     state_nx = SETTLE;
      SETTLE:  state_nx = WAIT;
      WAIT:    state_nx = finish ? (last ? IDLE : RUN) : (timeout ? IDLE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  // state, fifo bookkeeping, repeat counter and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      remaining <= '0;
      cmd_done <= 1'b0;
      runs_total <= '0;
    end else begin
      state <= state_nx;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      remaining <= pop ? head : (finish && !last ? remaining - CNT_W'(1) : remaining);
      cmd_done <= (pop && head == '0) || (finish && last);
      runs_total <= runs_total + 32'(finish);
    end
  end
  // command storage; occupancy lives in count so the data needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_iters;
  end
endmodule

// File: tb/tb_matmul_run_sequencer.sv
// tb_matmul_run_sequencer: random and directed stimulus checked against an event-timed command model
module tb_matmul_run_sequencer;
  logic clk = 0, rst = 1, cmd_valid = 0, done = 0;
  logic [15:0] cmd_iters = 0;
  logic cmd_ready, run, busy, cmd_done, error;
  logic [31:0] runs_total;
  int checks = 0, failures = 0;
  logic [15:0] rm, dm;
  int mode = 0;

  always #5 clk = ~clk;

  matmul_run_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_iters(cmd_iters), .run(run), .done(done), .busy(busy),
    .cmd_done(cmd_done), .runs_total(runs_total), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // model: queue of pending counts, the cycle the next run is due, and the cycle cmd_done is due
  int q[$];
  int cur = 0, run_at = -1, done_at = -1, cyc = 0, c;
  bit active = 0, armed = 0, nxt, rdy;
  logic [31:0] m_runs = 0;

  always @(negedge clk) begin : model
    if (armed) begin
      chk("run", run, active && run_at == cyc);
      chk("cmd_done", cmd_done, done_at == cyc);
      chk("busy", busy, active || q.size() > 0);
      chk("cmd_ready", cmd_ready, q.size() < 4);
      chk("runs_total", runs_total, m_runs);
      chk("error", error, 0);
    end
    if (rst) begin
      q.delete();
      active = 0;
      cur = 0;
      run_at = -1;
      done_at = -1;
      m_runs = 0;
      armed = 1;
    end else if (armed) begin
      nxt = active;
      rdy = q.size() < 4;
      if (active && cyc >= run_at + 2 && done) begin
        m_runs++;
        if (cur > 1) begin
          cur--;
          run_at = cyc + 1;
        end else begin
          done_at = cyc + 1;
          nxt = 0;
        end
      end
      if (!active && q.size() > 0) begin
        c = q.pop_front();
        if (c == 0) done_at = cyc + 1;
        else begin
          cur = c;
          run_at = cyc + 1;
          nxt = 1;
        end
      end
      if (cmd_valid && rdy) q.push_back(int'(cmd_iters));
      active = nxt;
    end
    cyc++;
  end

  task automatic push_one(input logic [15:0] v);
    @(posedge clk); #1 cmd_valid = 1; cmd_iters = v;
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic sample(input int n);
    rm = 0;
    dm = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rm[k] = run;
      dm[k] = cmd_done;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_run", run, 0);
    chk("reset_cmd_done", cmd_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_error", error, 0);
    chk("reset_runs_total", runs_total, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    done = 1;
    push_one(3);
    sample(14);
    chk("t1_run_cycles", rm, 16'h0124);
    chk("t1_cmd_done_cycle", dm, 16'h0800);
    chk("t1_runs_total", runs_total, 3);
    chk("t1_busy_low", busy, 0);
    push_one(0);
    sample(6);
    chk("zero_cmd_done_cycle", dm, 16'h0004);
    chk("zero_no_run", rm, 0);
    chk("zero_runs_total", runs_total, 3);
    do_reset();
    done = 0;
    @(posedge clk); #1 cmd_valid = 1; cmd_iters = 1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    done = 1;
    repeat (30) @(negedge clk);
    chk("full_runs_total", runs_total, 5);
    chk("full_drained_busy", busy, 0);
    chk("full_drained_ready", cmd_ready, 1);
    do_reset();
    push_one(4);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_run", run, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_done", cmd_done, 0);
    chk("midrst_runs_total", runs_total, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    sample(10);
    chk("midrst_no_run", rm, 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i % 200 == 0) mode = $urandom_range(0, 3);
      cmd_valid = $urandom_range(0, 2) == 0;
      cmd_iters = ($urandom_range(0, 19) == 0) ? 16'hffff : 16'($urandom_range(0, 4));
      done = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) == 0) :
             mode == 2 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rst = $urandom_range(0, 599) == 0;
    end
    @(posedge clk); #1 rst = 0; cmd_valid = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
